victim_cache_n: RTL and testbench
=================================

VICTIM_CACHE_N -- requirements
Module: victim_cache_n

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, meaning fully-associative entry count (power of 2, 2..16).
REQ-002 SHALL have parameter LINE_WIDTH, default 128, meaning cache-line bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, and OFFSET_BITS, default 4; TAG_WIDTH = ADDR_WIDTH-OFFSET_BITS.
REQ-004 SHALL use one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have l1_read  in  1  L1 miss request, held until l1_resp; l1_address  in  ADDR_WIDTH  requested line address.
REQ-006 SHALL have l1_evict_valid  in  1  L1 victim accompanies request; l1_evict_address  in  ADDR_WIDTH; l1_evict_data  in  LINE_WIDTH; l1_evict_dirty  in  1.
REQ-007 SHALL have l1_rdata  out  LINE_WIDTH  returned line; l1_resp  out  1  one-cycle completion pulse; l1_hit  out  1  qualifies l1_resp (1 = served from victim cache).
REQ-008 SHALL have pmem_read  out  1; pmem_write  out  1; pmem_address  out  ADDR_WIDTH; pmem_wdata  out  LINE_WIDTH; pmem_rdata  in  LINE_WIDTH; pmem_resp  in  1.

Function
REQ-009 SHALL implement FSM states IDLE, LOOKUP, WRITEBACK, FILL, RESP.
REQ-010 SHALL in IDLE with l1_read=1 register request and evict fields, go to LOOKUP; l1_read changes outside IDLE SHALL be ignored.
REQ-011 SHALL in LOOKUP compare registered tag against all valid tags in parallel; lowest matching index wins.
REQ-012 SHALL on hit: latch entry data to l1_rdata, write registered victim (if l1_evict_valid) into hit slot with its dirty bit, mark slot MRU, go to RESP.
REQ-013 SHALL on miss: select slot = first invalid entry, else LRU entry; if selected slot valid, dirty and l1_evict_valid then WRITEBACK, else FILL.
REQ-014 SHALL in WRITEBACK hold pmem_write=1, pmem_address={slot tag, OFFSET_BITS zeros}, pmem_wdata=slot data until pmem_resp, then FILL.
REQ-015 SHALL in FILL hold pmem_read=1, pmem_address={request tag, zeros} until pmem_resp; latch pmem_rdata to l1_rdata; install victim into slot if l1_evict_valid, mark MRU; go to RESP.
REQ-016 SHALL in RESP assert l1_resp=1 for exactly one cycle, return to IDLE; hit latency = 2 cycles after acceptance.
REQ-017 SHALL never assert pmem_read and pmem_write together.
REQ-018 SHALL, if victim tag equals an existing valid entry's tag, overwrite that entry rather than allocate.
REQ-019 SHALL leave entries and LRU unchanged on miss without l1_evict_valid.

Reset
REQ-020 SHALL on rst: FSM to IDLE, all valid and dirty bits 0, LRU order index 0 = LRU .. NUM_ENTRIES-1 = MRU, all outputs 0.
REQ-021 SHALL, on rst mid-transaction, drop pmem_read/pmem_write the next cycle and emit no l1_resp.

Configuration
REQ-022 SHALL with VICTIM_STATS_EN defined add outputs hit_count and miss_count (16 bits, saturating at 0xFFFF, increment in LOOKUP, cleared by rst); without it those ports and counters SHALL not exist.

Structure
REQ-023 SHALL place FSM state enum and default parameter constants in lc3b_types.
REQ-024 SHALL implement LRU as sub-module victim_lru_n (parametrised NUM_ENTRIES, touch/index in, lru index out).

Verification
REQ-025 Reset, l1_read addr 0x1230, no evict -> FILL, pmem_read addr 0x1230; pmem_resp data 0xA5.. -> l1_resp, l1_hit=0, l1_rdata 0xA5.., no entry written.
REQ-026 Read 0x1230 with evict 0x4560 dirty data D -> installed in entry 0; later read 0x4560 -> l1_resp 2 cycles after accept, l1_hit=1, l1_rdata D.
REQ-027 Fill all 4 entries dirty (0x1000..0x4000), then miss 0x5000 with evict 0x6000 -> pmem_write addr 0x1000 (LRU) first, then pmem_read 0x5000.
REQ-028 Hit 0x1000 before REQ-027 miss -> writeback address becomes 0x2000.
REQ-029 Assert rst during FILL with pmem_resp withheld -> pmem_read low next cycle, no l1_resp, subsequent read of 0x4560 misses.
REQ-030 With VICTIM_STATS_EN: 3 hits, 2 misses -> hit_count 3, miss_count 2; force 0xFFFF -> stays 0xFFFF on next hit.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types and default sizing for the victim cache: controller state encoding and parameter defaults.
package lc3b_types;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FILL      = 3'd3,
    S_RESP      = 3'd4
  } vc_state_e;

  localparam int VC_NUM_ENTRIES = 4;
  localparam int VC_LINE_WIDTH  = 128;
  localparam int VC_ADDR_WIDTH  = 16;
  localparam int VC_OFFSET_BITS = 4;

endpackage

// File: rtl/victim_cache_n_if.sv
// L1-side and physical-memory-side signals of the victim cache. The cache uses the slave modport,
// the surrounding L1 / memory environment uses the master modport.
interface victim_cache_n_if #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
);
  logic                  l1_read;
  logic [ADDR_WIDTH-1:0] l1_address;
  logic                  l1_evict_valid;
  logic [ADDR_WIDTH-1:0] l1_evict_address;
  logic [LINE_WIDTH-1:0] l1_evict_data;
  logic                  l1_evict_dirty;
  logic [LINE_WIDTH-1:0] l1_rdata;
  logic                  l1_resp;
  logic                  l1_hit;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  l1_read, l1_address, l1_evict_valid, l1_evict_address, l1_evict_data, l1_evict_dirty,
    input  pmem_rdata, pmem_resp,
    output l1_rdata, l1_resp, l1_hit, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output l1_read, l1_address, l1_evict_valid, l1_evict_address, l1_evict_data, l1_evict_dirty,
    output pmem_rdata, pmem_resp,
    input  l1_rdata, l1_resp, l1_hit, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/victim_lru_n.sv
// True-LRU tracker: keeps an ordered list of entry indices, slot 0 = least recently used.
module victim_lru_n #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           touch_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0] touch_idx_i,
  output logic [$clog2(NUM_ENTRIES)-1:0] lru_idx_o
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [IDX_W-1:0] order_q [NUM_ENTRIES];
  logic [IDX_W-1:0] order_d [NUM_ENTRIES];
  logic             found_s;

  // Remove the touched index from the list, close the gap, append it as MRU
  always_comb begin
    order_d = order_q;
    found_s = 1'b0;
    if (touch_i) begin
      for (int k = 0; k < NUM_ENTRIES - 1; k++) begin
        found_s    = found_s | (order_q[k] == touch_idx_i);
        order_d[k] = found_s ? order_q[k+1] : order_q[k];
      end
      order_d[NUM_ENTRIES-1] = touch_idx_i;
    end else begin
      order_d = order_q;
    end
  end

  // Order register, reset to identity (index 0 least recent)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_ENTRIES; k++) order_q[k] <= IDX_W'(k);
    end else begin
      order_q <= order_d;
    end
  end

  assign lru_idx_o = order_q[0];

endmodule

// File: rtl/victim_cache_n.sv
// Fully-associative victim cache between L1 and physical memory.
// Optional feature macro VICTIM_STATS_EN adds saturating hit_count / miss_count outputs.
module victim_cache_n
  import lc3b_types::*;
#(
  parameter int NUM_ENTRIES = VC_NUM_ENTRIES,
  parameter int LINE_WIDTH  = VC_LINE_WIDTH,
  parameter int ADDR_WIDTH  = VC_ADDR_WIDTH,
  parameter int OFFSET_BITS = VC_OFFSET_BITS
) (
  input logic clk,
  input logic rst,
  victim_cache_n_if.slave bus
`ifdef VICTIM_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;
  localparam int IDX_W     = $clog2(NUM_ENTRIES);

  typedef logic [TAG_WIDTH-1:0]  tag_t;
  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [IDX_W-1:0]      idx_t;

  vc_state_e state_q, state_d;
  tag_t      req_tag_q, ev_tag_q;
  line_t     ev_data_q;
  logic      ev_valid_q, ev_dirty_q;
  logic [NUM_ENTRIES-1:0] valid_q, dirty_q;
  tag_t      tag_q  [NUM_ENTRIES];
  line_t     data_q [NUM_ENTRIES];
  idx_t      slot_q, inst_q;
  line_t     rdata_q, pwdata_q, pwdata_d;
  logic      resp_q, hit_q, pread_q, pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;

  logic [NUM_ENTRIES-1:0] hit_vec_s, ev_vec_s, inv_vec_s;
  logic hit_s, ev_match_s, touch_s, install_s;
  idx_t lru_idx_s, sel_idx_s, inst_idx_s, wb_idx_s, touch_idx_s, install_idx_s;

  function automatic idx_t first_set(input logic [NUM_ENTRIES-1:0] v);
    first_set = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) if (v[i]) first_set = idx_t'(i);
  endfunction

  victim_lru_n #(.NUM_ENTRIES(NUM_ENTRIES)) u_lru (
    .clk(clk), .rst(rst), .touch_i(touch_s), .touch_idx_i(touch_idx_s), .lru_idx_o(lru_idx_s)
  );

  // Parallel tag match for the request and the incoming victim, plus free-slot search
  always_comb begin
    hit_vec_s = '0;
    ev_vec_s  = '0;
    inv_vec_s = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit_vec_s[i] = valid_q[i] & (tag_q[i] == req_tag_q);
      ev_vec_s[i]  = valid_q[i] & (tag_q[i] == ev_tag_q);
      inv_vec_s[i] = ~valid_q[i];
    end
    hit_s      = |hit_vec_s;
    ev_match_s = |ev_vec_s;
    sel_idx_s  = (|inv_vec_s) ? first_set(inv_vec_s) : lru_idx_s;
    inst_idx_s = ev_match_s ? first_set(ev_vec_s) : (hit_s ? first_set(hit_vec_s) : sel_idx_s);
    wb_idx_s   = (state_q == S_LOOKUP) ? sel_idx_s : slot_q;
  end

  // Next state, LRU touch and victim install decisions
  always_comb begin
    state_d       = state_q;
    touch_s       = 1'b0;
    touch_idx_s   = '0;
    install_s     = 1'b0;
    install_idx_s = inst_q;
    case (state_q)
      S_IDLE: begin
        if (bus.l1_read) state_d = S_LOOKUP;
        else             state_d = S_IDLE;
      end
      S_LOOKUP: begin
        install_idx_s = inst_idx_s;
        if (hit_s) begin
          state_d     = S_RESP;
          touch_s     = 1'b1;
          touch_idx_s = first_set(hit_vec_s);
          install_s   = ev_valid_q;
        end else if (ev_valid_q && valid_q[sel_idx_s] && dirty_q[sel_idx_s]) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WRITEBACK: begin
        if (bus.pmem_resp) state_d = S_FILL;
        else               state_d = S_WRITEBACK;
      end
      S_FILL: begin
        if (bus.pmem_resp) begin
          state_d     = S_RESP;
          touch_s     = ev_valid_q;
          touch_idx_s = inst_q;
          install_s   = ev_valid_q;
        end else begin
          state_d = S_FILL;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side address/data for the cycle the FSM is about to enter
  always_comb begin
    paddr_d  = '0;
    pwdata_d = '0;
    case (state_d)
      S_WRITEBACK: begin
        paddr_d  = {tag_q[wb_idx_s], {OFFSET_BITS{1'b0}}};
        pwdata_d = data_q[wb_idx_s];
      end
      S_FILL:  paddr_d = {req_tag_q, {OFFSET_BITS{1'b0}}};
      default: paddr_d = '0;
    endcase
  end

  // Controller state, entry storage and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      req_tag_q  <= '0;
      ev_tag_q   <= '0;
      ev_data_q  <= '0;
      ev_valid_q <= 1'b0;
      ev_dirty_q <= 1'b0;
      slot_q     <= '0;
      inst_q     <= '0;
      rdata_q    <= '0;
      resp_q     <= 1'b0;
      hit_q      <= 1'b0;
      pread_q    <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      state_q  <= state_d;
      resp_q   <= (state_d == S_RESP);
      pread_q  <= (state_d == S_FILL);
      pwrite_q <= (state_d == S_WRITEBACK);
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      if (state_q == S_IDLE && bus.l1_read) begin
        req_tag_q  <= bus.l1_address[ADDR_WIDTH-1:OFFSET_BITS];
        ev_valid_q <= bus.l1_evict_valid;
        ev_tag_q   <= bus.l1_evict_address[ADDR_WIDTH-1:OFFSET_BITS];
        ev_data_q  <= bus.l1_evict_data;
        ev_dirty_q <= bus.l1_evict_dirty;
      end
      if (state_q == S_LOOKUP) begin
        slot_q <= sel_idx_s;
        inst_q <= inst_idx_s;
        hit_q  <= hit_s;
        if (hit_s) rdata_q <= data_q[first_set(hit_vec_s)];
      end
      if (state_q == S_FILL && bus.pmem_resp) rdata_q <= bus.pmem_rdata;
      if (install_s) begin
        valid_q[install_idx_s] <= 1'b1;
        dirty_q[install_idx_s] <= ev_dirty_q;
        tag_q[install_idx_s]   <= ev_tag_q;
        data_q[install_idx_s]  <= ev_data_q;
      end
    end
  end

  assign bus.l1_rdata     = rdata_q;
  assign bus.l1_resp      = resp_q;
  assign bus.l1_hit       = hit_q;
  assign bus.pmem_read    = pread_q;
  assign bus.pmem_write   = pwrite_q;
  assign bus.pmem_address = paddr_q;
  assign bus.pmem_wdata   = pwdata_q;

`ifdef VICTIM_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Saturating lookup statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
    end else if (state_q == S_LOOKUP) begin
      if (hit_s && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'h0001;
      if (!hit_s && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'h0001;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_victim_cache_n.sv
// Self-checking bench for victim_cache_n: directed scenarios plus randomized traffic against a
// slot/LRU-queue reference model; the bench also plays the role of physical memory.
module tb_victim_cache_n;
  localparam int N  = 4;
  localparam int LW = 128;
  localparam int AW = 16;
  localparam int OB = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  victim_cache_n_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();
`ifdef VICTIM_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  victim_cache_n #(.NUM_ENTRIES(N), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .OFFSET_BITS(OB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef VICTIM_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // Reference model: entry contents by slot, recency as a queue (front = least recent)
  bit          m_valid [N];
  bit          m_dirty [N];
  logic [11:0] m_tag   [N];
  logic [LW-1:0] m_data [N];
  int          lru_q[$];

  function automatic void model_reset();
    lru_q.delete();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      lru_q.push_back(i);
    end
  endfunction

  function automatic void lru_touch(input int idx);
    for (int k = 0; k < lru_q.size(); k++) begin
      if (lru_q[k] == idx) begin
        lru_q.delete(k);
        break;
      end
    end
    lru_q.push_back(idx);
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_inputs();
    bus.l1_read = 1'b0; bus.l1_address = '0; bus.l1_evict_valid = 1'b0;
    bus.l1_evict_address = '0; bus.l1_evict_data = '0; bus.l1_evict_dirty = 1'b0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One L1 request, served end to end; the model predicts hit/miss, memory traffic and data
  task automatic do_req(input logic [15:0] addr, input bit evv, input logic [15:0] eva,
                        input logic [LW-1:0] evd, input bit evdirty, input logic [LW-1:0] fill,
                        input int delay, output bit got_hit, output logic [15:0] got_wb);
    int h, em, sel, tgt, wait_cnt;
    bit exp_wb, saw_wb, saw_rd, busy, done;
    logic [LW-1:0] exp_rdata;
    h = -1; em = -1; sel = -1;
    for (int i = 0; i < N; i++) begin
      if (h < 0 && m_valid[i] && m_tag[i] == addr[15:4]) h = i;
      if (em < 0 && m_valid[i] && m_tag[i] == eva[15:4]) em = i;
      if (sel < 0 && !m_valid[i]) sel = i;
    end
    if (sel < 0) sel = lru_q[0];
    exp_wb    = (h < 0) && evv && m_valid[sel] && m_dirty[sel];
    exp_rdata = (h >= 0) ? m_data[h] : fill;
    tgt       = (em >= 0) ? em : ((h >= 0) ? h : sel);
    got_hit = 1'b0; got_wb = '0; saw_wb = 1'b0; saw_rd = 1'b0; busy = 1'b0; done = 1'b0; wait_cnt = 0;

    @(negedge clk);
    bus.l1_read = 1'b1; bus.l1_address = addr; bus.l1_evict_valid = evv;
    bus.l1_evict_address = eva; bus.l1_evict_data = evd; bus.l1_evict_dirty = evdirty;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      checks++;
      if (bus.pmem_read && bus.pmem_write) begin
        errors++; $display("FAIL pmem_exclusive: read and write both high at addr %h", addr);
      end
      if (bus.l1_resp) begin
        done = 1'b1;
        got_hit = bus.l1_hit;
        checks++;
        if (bus.l1_hit !== (h >= 0)) begin
          errors++; $display("FAIL l1_hit addr %h: got %b expected %b", addr, bus.l1_hit, h >= 0);
        end
        checks++;
        if (bus.l1_rdata !== exp_rdata) begin
          errors++; $display("FAIL l1_rdata addr %h: got %h expected %h", addr, bus.l1_rdata, exp_rdata);
        end
        checks++;
        if (h >= 0 && cyc != 2) begin
          errors++; $display("FAIL hit_latency addr %h: got %0d cycles expected 2", addr, cyc);
        end else if (h < 0 && !saw_rd) begin
          errors++; $display("FAIL miss_no_fill addr %h: response without pmem_read", addr);
        end
      end else if (bus.pmem_write || bus.pmem_read) begin
        if (!busy) begin
          busy = 1'b1;
          wait_cnt = delay;
          if (bus.pmem_write) begin
            saw_wb = 1'b1;
            got_wb = bus.pmem_address;
            checks++;
            if (!exp_wb || saw_rd) begin
              errors++; $display("FAIL wb_unexpected addr %h: got write %h expected none", addr, bus.pmem_address);
            end
            checks++;
            if (bus.pmem_address !== {m_tag[sel], 4'h0} || bus.pmem_wdata !== m_data[sel]) begin
              errors++; $display("FAIL wb_addr_data: got %h/%h expected %h/%h", bus.pmem_address,
                                 bus.pmem_wdata, {m_tag[sel], 4'h0}, m_data[sel]);
            end
          end else begin
            saw_rd = 1'b1;
            bus.pmem_rdata = fill;
            checks++;
            if (bus.pmem_address !== {addr[15:4], 4'h0}) begin
              errors++; $display("FAIL fill_addr: got %h expected %h", bus.pmem_address, {addr[15:4], 4'h0});
            end
            checks++;
            if (h >= 0 || saw_wb != exp_wb) begin
              errors++; $display("FAIL fill_order addr %h: got wb_seen=%b expected %b (hit=%0d)", addr, saw_wb, exp_wb, h);
            end
          end
        end
        if (wait_cnt == 0) begin
          bus.pmem_resp = 1'b1;
          busy = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
    bus.l1_read = 1'b0;
    bus.l1_evict_valid = 1'b0;
    bus.pmem_resp = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr %h: got no l1_resp expected one within 400 cycles", addr);
    end
    @(negedge clk);
    checks++;
    if (bus.l1_resp !== 1'b0) begin
      errors++; $display("FAIL resp_pulse addr %h: got l1_resp=%b expected 0", addr, bus.l1_resp);
    end
    if (h >= 0) lru_touch(h);
    if (evv) begin
      m_valid[tgt] = 1'b1; m_dirty[tgt] = evdirty; m_tag[tgt] = eva[15:4]; m_data[tgt] = evd;
      if (h < 0) lru_touch(tgt);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.l1_resp, bus.l1_hit, bus.pmem_read, bus.pmem_write} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000",
                         {bus.l1_resp, bus.l1_hit, bus.pmem_read, bus.pmem_write});
    end
    checks++;
    if (bus.pmem_address !== 16'h0000 || bus.pmem_wdata !== '0 || bus.l1_rdata !== '0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h expected zeros", bus.pmem_address, bus.pmem_wdata, bus.l1_rdata);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_miss_fill();
    bit hit; logic [15:0] wb;
    logic [LW-1:0] a5 = {16{8'hA5}};
    do_reset();
    do_req(16'h1230, 1'b0, 16'h0000, '0, 1'b0, a5, 2, hit, wb);
    do_req(16'h1230, 1'b0, 16'h0000, '0, 1'b0, rnd_line(), 0, hit, wb);
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL miss_no_install: got hit=%b expected 0", hit);
    end
  endtask

  task automatic test_victim_hit();
    bit hit; logic [15:0] wb;
    logic [LW-1:0] d = rnd_line();
    do_reset();
    do_req(16'h1230, 1'b1, 16'h4560, d, 1'b1, rnd_line(), 1, hit, wb);
    do_req(16'h4560, 1'b0, 16'h0000, '0, 1'b0, rnd_line(), 0, hit, wb);
    checks++;
    if (hit !== 1'b1) begin
      errors++; $display("FAIL victim_hit: got hit=%b expected 1", hit);
    end
  endtask

  task automatic test_writeback_lru(input bit touch_first, input logic [15:0] exp_wb);
    bit hit; logic [15:0] wb;
    do_reset();
    for (int k = 0; k < 4; k++)
      do_req(16'(16'h8000 + k * 16'h0100), 1'b1, 16'(16'h1000 * (k + 1)), rnd_line(), 1'b1, rnd_line(), 0, hit, wb);
    if (touch_first) do_req(16'h1000, 1'b0, 16'h0000, '0, 1'b0, rnd_line(), 0, hit, wb);
    do_req(16'h5000, 1'b1, 16'h6000, rnd_line(), 1'b1, rnd_line(), 1, hit, wb);
    checks++;
    if (wb !== exp_wb) begin
      errors++; $display("FAIL lru_writeback: got %h expected %h", wb, exp_wb);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit hit, seen, resp_seen; logic [15:0] wb;
    do_reset();
    @(negedge clk);
    bus.l1_read = 1'b1; bus.l1_address = 16'h1230; bus.l1_evict_valid = 1'b1;
    bus.l1_evict_address = 16'h4560; bus.l1_evict_data = rnd_line(); bus.l1_evict_dirty = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.pmem_read) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL reset_fill_start: got no pmem_read expected one");
    end
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      errors++; $display("FAIL reset_drop_pmem: got rd=%b wr=%b expected 0/0", bus.pmem_read, bus.pmem_write);
    end
    rst = 1'b0;
    resp_seen = bus.l1_resp;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      resp_seen = resp_seen | bus.l1_resp;
    end
    checks++;
    if (resp_seen !== 1'b0) begin
      errors++; $display("FAIL reset_no_resp: got l1_resp=%b expected 0", resp_seen);
    end
    model_reset();
    do_req(16'h4560, 1'b0, 16'h0000, '0, 1'b0, rnd_line(), 0, hit, wb);
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL reset_cleared: got hit=%b expected 0", hit);
    end
  endtask

  task automatic test_random();
    bit hit; logic [15:0] wb;
    int t, t2;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      t  = $urandom_range(0, 7);
      t2 = (t + 1 + $urandom_range(0, 6)) % 8;
      do_req(16'(16'h0100 * (t + 1) + $urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             16'(16'h0100 * (t2 + 1)), rnd_line(), 1'($urandom_range(0, 1)), rnd_line(),
             $urandom_range(0, 3), hit, wb);
    end
  endtask

`ifdef VICTIM_STATS_EN
  task automatic test_stats();
    bit hit; logic [15:0] wb;
    do_reset();
    do_req(16'h1230, 1'b1, 16'h4560, rnd_line(), 1'b0, rnd_line(), 0, hit, wb);
    repeat (3) do_req(16'h4560, 1'b0, 16'h0000, '0, 1'b0, rnd_line(), 0, hit, wb);
    do_req(16'h7770, 1'b0, 16'h0000, '0, 1'b0, rnd_line(), 0, hit, wb);
    checks++;
    if (hit_count !== 16'd3 || miss_count !== 16'd2) begin
      errors++; $display("FAIL stats_count: got %0d/%0d expected 3/2", hit_count, miss_count);
    end
    force dut.hit_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.hit_cnt_q;
    do_req(16'h4560, 1'b0, 16'h0000, '0, 1'b0, rnd_line(), 0, hit, wb);
    checks++;
    if (hit_count !== 16'hFFFF) begin
      errors++; $display("FAIL stats_saturate: got %h expected ffff", hit_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_miss_fill();
    test_victim_hit();
    test_writeback_lru(1'b0, 16'h1000);
    test_writeback_lru(1'b1, 16'h2000);
    test_reset_mid_fill();
    test_random();
`ifdef VICTIM_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
